// File: rtl/dcache_mem_requester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_mem_requester_pkg
//  Description : Shared definitions for the data-cache memory requester.
//                Holds the default line geometry, the requester state
//                encoding and the write_or_read polarity constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_mem_requester_pkg;

    // Common cache geometry defaults
    localparam int DEF_LINE_WIDTH     = 128;
    localparam int DEF_PHYS_ADDR_SIZE = 20;
    localparam int DEF_OFFSET_BITS    = 4;

    // Requester state encoding
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_wb_req   = 3'd1;
    localparam logic [2:0] c_st_wb_gap   = 3'd2;
    localparam logic [2:0] c_st_fill_req = 3'd3;
    localparam logic [2:0] c_st_done     = 3'd4;

    // write_or_read polarity on the cache-to-memory interface
    localparam logic c_write = 1'b1;
    localparam logic c_read  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/dcache_mem_requester_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : req_timeout_counter
//  Description : Sticky protocol-timeout detector. Counts cycles in which a
//                request is active but not yet acknowledged; once the count
//                reaches TIMEOUT_CYCLES the timeout flag sets and stays set
//                until reset.
//  Ports       : clk, reset (async, active-low)
//                active  - request enable currently asserted
//                ready   - request acknowledged this cycle
//                clear   - restart the count (requester state change)
//                timeout - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module req_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_limit    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] c_limit_m1 = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_count;
    logic          r_timeout;
    logic          w_waiting;

    assign w_waiting = active & ~ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (clear) begin
                r_count <= '0;
            end else if (w_waiting && (r_count != c_limit)) begin
                // Saturate at the limit so a very long stall never wraps
                r_count <= r_count + TW'(1);
            end
            // Flag sets on the edge that completes the TIMEOUT_CYCLES-th wait
            if (!clear && w_waiting && (r_count == c_limit_m1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/dcache_mem_requester.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_mem_requester
//  Description : Cache-side initiator of the cache-to-memory line interface.
//                Each accepted miss performs an optional dirty-victim
//                writeback followed by a line fill, returns the filled line
//                to the cache core and keeps sticky/statistics status.
//  Ports       : clk, reset (async, active-low)
//                miss_*/victim_*  - miss request from the cache core
//                fill_*           - filled line back to the cache core
//                mem_*            - to/from the arbiter d_cache_* port
//                mem_timeout, miss_count, wb_count - status and statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_mem_requester
    import dcache_mem_requester_pkg::*;
#(
    parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
    parameter int ADDR_SIZE      = DEF_PHYS_ADDR_SIZE,
    parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_SIZE-1:0]  miss_address,
    input  logic                  victim_dirty,
    input  logic [ADDR_SIZE-1:0]  victim_address,
    input  logic [LINE_WIDTH-1:0] victim_data,
    output logic                  miss_busy,
    output logic                  fill_valid,
    output logic [ADDR_SIZE-1:0]  fill_address,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic [ADDR_SIZE-1:0]  mem_address,
    output logic [LINE_WIDTH-1:0] mem_in_data,
    output logic                  mem_write_or_read,
    output logic                  mem_enable,
    input  logic [LINE_WIDTH-1:0] mem_out_data,
    input  logic                  mem_ready,
    output logic                  mem_timeout,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    localparam logic [ADDR_SIZE-1:0] c_align_mask =
        {{(ADDR_SIZE - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [ADDR_SIZE-1:0]  r_miss_addr;
    logic                  r_victim_dirty;
    logic [ADDR_SIZE-1:0]  r_victim_addr;
    logic [LINE_WIDTH-1:0] r_victim_data;
    logic [ADDR_SIZE-1:0]  r_fill_addr;
    logic [LINE_WIDTH-1:0] r_fill_data;
    logic [CNT_WIDTH-1:0]  r_miss_count;
    logic [CNT_WIDTH-1:0]  r_wb_count;

    logic                  w_in_wb;
    logic                  w_in_fill;
    logic                  w_accept;
    logic [ADDR_SIZE-1:0]  w_miss_line;
    logic [ADDR_SIZE-1:0]  w_victim_line;

    assign w_in_wb       = (r_state == c_st_wb_req);
    assign w_in_fill     = (r_state == c_st_fill_req);
    assign w_accept      = (r_state == c_st_idle) && miss_valid;
    assign w_miss_line   = r_miss_addr & c_align_mask;
    assign w_victim_line = r_victim_addr & c_align_mask;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // mem_ready only matters in the two request states, so spurious
    // ready pulses in IDLE/WB_GAP/DONE fall through untouched.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (miss_valid) begin
                    w_state_next = victim_dirty ? c_st_wb_req : c_st_fill_req;
                end
            end
            c_st_wb_req: begin
                if (mem_ready) begin
                    w_state_next = c_st_wb_gap;
                end
            end
            c_st_wb_gap: begin
                w_state_next = c_st_fill_req;
            end
            c_st_fill_req: begin
                if (mem_ready) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ---------------- request latch, fill capture, statistics ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miss_addr    <= '0;
            r_victim_dirty <= 1'b0;
            r_victim_addr  <= '0;
            r_victim_data  <= '0;
            r_fill_addr    <= '0;
            r_fill_data    <= '0;
            r_miss_count   <= '0;
            r_wb_count     <= '0;
        end else begin
            if (w_accept) begin
                r_miss_addr    <= miss_address;
                r_victim_dirty <= victim_dirty;
                r_victim_addr  <= victim_address;
                r_victim_data  <= victim_data;
                r_miss_count   <= r_miss_count + CNT_WIDTH'(1);
            end
            if (w_in_wb && mem_ready && r_victim_dirty) begin
                r_wb_count <= r_wb_count + CNT_WIDTH'(1);
            end
            if (w_in_fill && mem_ready) begin
                r_fill_data <= mem_out_data;
                r_fill_addr <= w_miss_line;
            end
        end
    end

    // ---------------- timeout monitor ----------------
    req_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .active  (mem_enable),
        .ready   (mem_ready),
        .clear   (w_state_next != r_state),
        .timeout (mem_timeout)
    );

    // ---------------- outputs, decoded from the registered state ----------------
    assign miss_busy         = (r_state != c_st_idle);
    assign fill_valid        = (r_state == c_st_done);
    assign fill_address      = r_fill_addr;
    assign fill_data         = r_fill_data;
    assign mem_enable        = w_in_wb | w_in_fill;
    assign mem_write_or_read = w_in_wb ? c_write : c_read;
    assign mem_address       = w_in_wb ? w_victim_line : (w_in_fill ? w_miss_line : '0);
    assign mem_in_data       = w_in_wb ? r_victim_data : '0;
    assign miss_count        = r_miss_count;
    assign wb_count          = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_mem_requester
//  Description : Self-checking bench for dcache_mem_requester. The bench
//                plays the memory arbiter, times each request from the
//                protocol rules and checks every visible output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_requester;

    localparam int LW = 128;
    localparam int AW = 20;
    localparam int CW = 16;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_valid;
    logic [AW-1:0] miss_address;
    logic          victim_dirty;
    logic [AW-1:0] victim_address;
    logic [LW-1:0] victim_data;
    logic          miss_busy;
    logic          fill_valid;
    logic [AW-1:0] fill_address;
    logic [LW-1:0] fill_data;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_in_data;
    logic          mem_write_or_read;
    logic          mem_enable;
    logic [LW-1:0] mem_out_data;
    logic          mem_ready;
    logic          mem_timeout;
    logic [CW-1:0] miss_count;
    logic [CW-1:0] wb_count;

    dcache_mem_requester #(
        .LINE_WIDTH     (LW),
        .ADDR_SIZE      (AW),
        .OFFSET_BITS    (4),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .miss_valid        (miss_valid),
        .miss_address      (miss_address),
        .victim_dirty      (victim_dirty),
        .victim_address    (victim_address),
        .victim_data       (victim_data),
        .miss_busy         (miss_busy),
        .fill_valid        (fill_valid),
        .fill_address      (fill_address),
        .fill_data         (fill_data),
        .mem_address       (mem_address),
        .mem_in_data       (mem_in_data),
        .mem_write_or_read (mem_write_or_read),
        .mem_enable        (mem_enable),
        .mem_out_data      (mem_out_data),
        .mem_ready         (mem_ready),
        .mem_timeout       (mem_timeout),
        .miss_count        (miss_count),
        .wb_count          (wb_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state kept from the protocol rules
    int            exp_miss;
    int            exp_wb;
    logic          exp_to;
    logic [LW-1:0] exp_fd;
    logic [AW-1:0] exp_fa;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:4], 4'h0};
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete miss transaction; the bench answers each request after
    // the given number of stalled cycles. Called just after an edge with the
    // requester idle.
    task automatic run_miss(input logic [AW-1:0] ma, input logic dirty,
                            input logic [AW-1:0] va, input logic [LW-1:0] vd,
                            input logic [LW-1:0] rd, input int wb_wait,
                            input int fill_wait);
        miss_valid     = 1'b1;
        miss_address   = ma;
        victim_dirty   = dirty;
        victim_address = va;
        victim_data    = vd;
        step();
        // Scramble the request inputs: the requester must use its latched copy
        miss_valid     = 1'b0;
        miss_address   = AW'($urandom());
        victim_dirty   = 1'($urandom());
        victim_address = AW'($urandom());
        victim_data    = rnd_line();
        exp_miss++;
        chk("busy_after_accept", LW'(miss_busy), LW'(1));
        chk("miss_count", LW'(miss_count), LW'(exp_miss[CW-1:0]));
        if (dirty) begin
            for (int i = 0; i <= wb_wait; i++) begin
                exp_to = exp_to | (i >= TO);
                chk("wb_enable", LW'(mem_enable), LW'(1));
                chk("wb_wr", LW'(mem_write_or_read), LW'(1));
                chk("wb_addr", LW'(mem_address), LW'(align(va)));
                chk("wb_data", mem_in_data, vd);
                chk("wb_timeout", LW'(mem_timeout), LW'(exp_to));
                mem_ready    = (i == wb_wait);
                mem_out_data = rnd_line();
                step();
            end
            exp_wb++;
            // Gap cycle: a spurious ready here must be ignored
            chk("gap_enable", LW'(mem_enable), LW'(0));
            chk("gap_busy", LW'(miss_busy), LW'(1));
            chk("wb_count", LW'(wb_count), LW'(exp_wb[CW-1:0]));
            mem_ready    = 1'($urandom());
            mem_out_data = rnd_line();
            step();
        end
        for (int i = 0; i <= fill_wait; i++) begin
            exp_to = exp_to | (i >= TO);
            chk("fill_enable", LW'(mem_enable), LW'(1));
            chk("fill_wr", LW'(mem_write_or_read), LW'(0));
            chk("fill_addr_req", LW'(mem_address), LW'(align(ma)));
            chk("fill_in_data", mem_in_data, '0);
            chk("fill_timeout", LW'(mem_timeout), LW'(exp_to));
            chk("no_early_fill", LW'(fill_valid), LW'(0));
            mem_ready    = (i == fill_wait);
            mem_out_data = (i == fill_wait) ? rd : rnd_line();
            step();
        end
        exp_fd = rd;
        exp_fa = align(ma);
        chk("done_fill_valid", LW'(fill_valid), LW'(1));
        chk("done_fill_data", fill_data, exp_fd);
        chk("done_fill_addr", LW'(fill_address), LW'(exp_fa));
        chk("done_enable", LW'(mem_enable), LW'(0));
        chk("done_timeout", LW'(mem_timeout), LW'(exp_to));
        // Spurious ready during DONE
        mem_ready    = 1'($urandom());
        mem_out_data = rnd_line();
        step();
        chk("idle_fill_valid", LW'(fill_valid), LW'(0));
        chk("idle_busy", LW'(miss_busy), LW'(0));
        chk("idle_fill_data", fill_data, exp_fd);
        chk("wb_count_end", LW'(wb_count), LW'(exp_wb[CW-1:0]));
    endtask

    // Idle cycles with random ready/data noise and no request
    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready    = 1'($urandom());
            mem_out_data = rnd_line();
            step();
            chk("noise_busy", LW'(miss_busy), LW'(0));
            chk("noise_fill_valid", LW'(fill_valid), LW'(0));
            chk("noise_fill_data", fill_data, exp_fd);
            chk("noise_fill_addr", LW'(fill_address), LW'(exp_fa));
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        miss_valid     = 1'b0;
        miss_address   = '0;
        victim_dirty   = 1'b0;
        victim_address = '0;
        victim_data    = '0;
        mem_out_data   = '0;
        mem_ready      = 1'b0;
        exp_miss       = 0;
        exp_wb         = 0;
        exp_to         = 1'b0;
        exp_fd         = '0;
        exp_fa         = '0;

        // Reset state
        step();
        step();
        chk("rst_busy", LW'(miss_busy), LW'(0));
        chk("rst_fill_valid", LW'(fill_valid), LW'(0));
        chk("rst_fill_addr", LW'(fill_address), LW'(0));
        chk("rst_fill_data", fill_data, '0);
        chk("rst_mem_addr", LW'(mem_address), LW'(0));
        chk("rst_mem_in", mem_in_data, '0);
        chk("rst_wr", LW'(mem_write_or_read), LW'(0));
        chk("rst_enable", LW'(mem_enable), LW'(0));
        chk("rst_timeout", LW'(mem_timeout), LW'(0));
        chk("rst_miss_count", LW'(miss_count), LW'(0));
        chk("rst_wb_count", LW'(wb_count), LW'(0));
        reset = 1'b1;
        step();

        // Clean miss, ready three cycles after enable
        run_miss(20'h01234, 1'b0, 20'h0, '0, {8{16'hCAFE}}, 0, 3);
        idle_noise(3);

        // Dirty miss: writeback, one gap cycle, then fill
        run_miss(20'h00010, 1'b1, 20'h0ABCD, {8{16'h5555}}, rnd_line(), 2, 1);
        idle_noise(2);

        // Ready effectively tied high: clean and dirty back to back
        run_miss(AW'($urandom()), 1'b0, AW'($urandom()), rnd_line(), rnd_line(), 0, 0);
        run_miss(AW'($urandom()), 1'b1, AW'($urandom()), rnd_line(), rnd_line(), 0, 0);

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            run_miss(AW'($urandom()), 1'($urandom()), AW'($urandom()), rnd_line(),
                     rnd_line(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            idle_noise(int'($urandom_range(0, 2)));
        end

        // Long stall: timeout sets after TO waiting cycles, fill still completes
        run_miss(AW'($urandom()), 1'b0, AW'($urandom()), rnd_line(), rnd_line(), 0, 300);
        chk("timeout_sticky", LW'(mem_timeout), LW'(1));
        idle_noise(2);
        chk("timeout_sticky_idle", LW'(mem_timeout), LW'(1));

        // Reset asserted while waiting in the fill request
        run_miss(AW'($urandom()), 1'b1, AW'($urandom()), rnd_line(), rnd_line(), 1, 0);
        miss_valid   = 1'b1;
        miss_address = AW'($urandom());
        victim_dirty = 1'b0;
        step();
        miss_valid = 1'b0;
        mem_ready  = 1'b0;
        step();
        chk("pre_reset_enable", LW'(mem_enable), LW'(1));
        reset = 1'b0;
        #1;
        chk("async_rst_enable", LW'(mem_enable), LW'(0));
        chk("async_rst_busy", LW'(miss_busy), LW'(0));
        chk("async_rst_fill_valid", LW'(fill_valid), LW'(0));
        chk("async_rst_miss_count", LW'(miss_count), LW'(0));
        chk("async_rst_wb_count", LW'(wb_count), LW'(0));
        chk("async_rst_timeout", LW'(mem_timeout), LW'(0));
        chk("async_rst_fill_data", fill_data, '0);
        exp_miss = 0;
        exp_wb   = 0;
        exp_to   = 1'b0;
        exp_fd   = '0;
        exp_fa   = '0;
        mem_ready = 1'b1;
        step();
        chk("rst_held_fill_valid", LW'(fill_valid), LW'(0));
        chk("rst_held_enable", LW'(mem_enable), LW'(0));
        mem_ready = 1'b0;
        reset     = 1'b1;
        step();
        idle_noise(1);

        // Service resumes normally after reset
        run_miss(AW'($urandom()), 1'b1, AW'($urandom()), rnd_line(), rnd_line(), 2, 2);
        run_miss(AW'($urandom()), 1'b0, AW'($urandom()), rnd_line(), rnd_line(), 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_mem_requester.md
Name: dcache_mem_requester

Overview:
- Cache-side initiator of the cache-to-memory line interface; drives address, enable, write_or_read and write data, then waits for ready.
- Instantiated inside the data cache. Its mem_* ports connect to the d_cache_* ports of the memory arbiter.
- Each accepted miss runs one transaction sequence: an optional dirty-victim writeback, then a line fill.
- Returns the filled line to the cache core and keeps sticky status and wrapping statistics.

Parameters:
- LINE_WIDTH, 128: bits per cache line.
- ADDR_SIZE, 20: physical address width.
- OFFSET_BITS, 4: line byte-offset bits. These are forced to zero on every mem_address.
- TIMEOUT_CYCLES, 255: maximum cycles mem_enable may stay high without mem_ready before mem_timeout sets.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
- miss_valid  in  1  cache core requests service of a miss.
- miss_address  in  ADDR_SIZE  address of the missing line.
- victim_dirty  in  1  the victim line must be written back first.
- victim_address  in  ADDR_SIZE  address of the victim line.
- victim_data  in  LINE_WIDTH  victim line contents.
- miss_busy  out  1  high whenever the FSM is not IDLE.
- fill_valid  out  1  one-cycle pulse: fill_data/fill_address are valid.
- fill_address  out  ADDR_SIZE  line-aligned address of the filled line.
- fill_data  out  LINE_WIDTH  line returned from memory.
- mem_address  out  ADDR_SIZE  to arbiter d_cache_address.
- mem_in_data  out  LINE_WIDTH  to arbiter d_cache_in_data.
- mem_write_or_read  out  1  to arbiter d_cache_write_or_read; 1 = write, 0 = read.
- mem_enable  out  1  to arbiter d_cache_enable.
- mem_out_data  in  LINE_WIDTH  from arbiter d_cache_out_data.
- mem_ready  in  1  from arbiter d_cache_ready.
- mem_timeout  out  1  sticky protocol-timeout flag.
- miss_count  out  CNT_WIDTH  number of accepted misses.
- wb_count  out  CNT_WIDTH  number of completed writebacks.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All outputs 0: miss_busy, fill_valid, fill_address, fill_data, mem_address, mem_in_data, mem_write_or_read, mem_enable, mem_timeout, miss_count, wb_count.
  - Latched request registers and the timeout counter are cleared.
- FSM states: IDLE, WB_REQ, WB_GAP, FILL_REQ, DONE.
- IDLE:
  - If miss_valid=1 at an edge, latch miss_address, victim_dirty, victim_address and victim_data; increment miss_count.
  - Next state is WB_REQ if victim_dirty=1, otherwise FILL_REQ.
  - miss_valid is ignored in every other state; the core holds it until it sees miss_busy=0.
- WB_REQ:
  - Outputs: mem_enable=1, mem_write_or_read=1, mem_address = victim_address with low OFFSET_BITS zeroed, mem_in_data = victim_data.
  - These outputs are held stable until mem_ready=1 is sampled.
  - On mem_ready=1: go to WB_GAP and increment wb_count.
- WB_GAP:
  - mem_enable=0 for exactly one cycle, so back-to-back requests always have a deasserted gap. Then go to FILL_REQ.
- FILL_REQ:
  - Outputs: mem_enable=1, mem_write_or_read=0, mem_address = aligned miss_address, mem_in_data = 0.
  - On mem_ready=1: register mem_out_data into fill_data and the aligned miss_address into fill_address; go to DONE.
- DONE:
  - fill_valid=1 and mem_enable=0 for one cycle, then go to IDLE.
  - fill_data and fill_address hold until the next fill.
- Outputs are registered and decoded from state only. mem_enable rises the cycle after acceptance or after WB_GAP.
- Latency:
  - Clean miss: acceptance at edge 0, mem_enable high from cycle 1. If mem_ready is sampled at edge k, fill_valid is high during cycle k+1.
  - Dirty miss adds the writeback duration plus 1 gap cycle.
- mem_ready sampled while mem_enable=0 is ignored; it causes no state change and no data capture.
- mem_ready held high continuously: each request completes in 1 cycle. The gap and DONE cycles still occur.
- Timeout:
  - A counter increments each cycle mem_enable=1 and mem_ready=0, and clears on every state transition.
  - When it reaches TIMEOUT_CYCLES, mem_timeout sets and stays set until reset.
  - The FSM keeps waiting; the request is never abandoned.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- Reset asserted mid-transaction: the FSM returns to IDLE and mem_enable drops immediately (asynchronous). No fill_valid pulse, and the counters clear.

Decomposition:
- Shared package holds:
  - the state encoding (2-3 bit localparams IDLE..DONE);
  - the LINE_WIDTH, PHYS_ADDR_SIZE and OFFSET_BITS defaults from the common preprocessor directives;
  - WRITE=1 / READ=0 constants for write_or_read.
- One natural sub-module: req_timeout_counter. It takes clk, reset, active, ready and clear; its output is a sticky timeout.
- FSM, latch registers and statistics counters stay in the top module.

Test Plan:
- Clean miss: miss_valid=1, miss_address=0x01234, victim_dirty=0; memory asserts ready 3 cycles after enable with data 0xCAFE...
  -> mem_address=0x01230, write_or_read=0; fill_valid pulses 1 cycle with fill_data=0xCAFE..., fill_address=0x01230; miss_count=1.
- Dirty miss: victim_address=0x0ABCD, victim_data=0x55..55, miss_address=0x00010.
  -> write to 0x0ABC0 with data 0x55..55; exactly 1 cycle with enable=0; then read of 0x00010; wb_count=1, miss_count=1.
- mem_ready tied high.
  -> clean miss completes with fill_valid 2 cycles after acceptance; dirty miss completes in 4.
- Spurious mem_ready=1 pulses while in IDLE, WB_GAP and DONE.
  -> no state change, fill_data unchanged, no extra fill_valid.
- mem_ready withheld for 300 cycles with TIMEOUT_CYCLES=255.
  -> mem_timeout rises after 255 waiting cycles and stays high; ready at cycle 300 still completes the fill normally.
- reset=0 asserted during FILL_REQ.
  -> mem_enable=0 and miss_busy=0 immediately; no fill_valid; counters read 0; a new miss after reset release is serviced normally.
